// File: rtl/riscv_regfile_sb.sv
// riscv_regfile_sb
// Integer register file x1..x31 (x0 hardwired to zero) with an in-flight
// write scoreboard.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   rf_wen/waddr/wdata  commit-side write port
//   rdN_en/rdN_addr     read requests (N = 0,1)
//   rdN_data            registered read data, with write-first bypass
//   rdN_valid           registered rdN_en
//   rdN_busy            registered "operand has an uncommitted producer"
//   sb_set/sb_set_addr  dispatch reserves a destination register
//   sb_set_ready        combinational; low while the destination counter is saturated
//   flush               clears every pending reservation
//   busy_cnt            registered count of registers with a nonzero pending count
module riscv_regfile_sb #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rf_wen,
    input  logic [4:0]      rf_waddr,
    input  logic [XLEN-1:0] rf_wdata,
    input  logic            rd0_en,
    input  logic [4:0]      rd0_addr,
    input  logic            rd1_en,
    input  logic [4:0]      rd1_addr,
    output logic [XLEN-1:0] rd0_data,
    output logic [XLEN-1:0] rd1_data,
    output logic            rd0_valid,
    output logic            rd1_valid,
    output logic            rd0_busy,
    output logic            rd1_busy,
    input  logic            sb_set,
    input  logic [4:0]      sb_set_addr,
    output logic            sb_set_ready,
    input  logic            flush,
    output logic [5:0]      busy_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Entry 0 is never written; every read path forces x0 to zero before
    // looking at the array.
    logic [XLEN-1:0]  mem [32];
    logic [CNT_W-1:0] cnt_reg  [32];
    logic [CNT_W-1:0] cnt_next [32];
    logic [5:0]       busy_cnt_reg;
    logic [5:0]       busy_cnt_next;
    logic             rd_en   [2];
    logic [4:0]       rd_addr [2];

    assign rd_en[0]   = rd0_en;
    assign rd_en[1]   = rd1_en;
    assign rd_addr[0] = rd0_addr;
    assign rd_addr[1] = rd1_addr;

    // ------------------------------------------------------------------
    // Storage: no reset, write ignored for x0.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rf_wen && rf_waddr != 5'd0) begin
            mem[rf_waddr] <= rf_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard counters
    // ------------------------------------------------------------------
    assign sb_set_ready = (sb_set_addr == 5'd0) || (cnt_reg[sb_set_addr] != CNT_MAX);

    assign cnt_next[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_cnt
            logic inc;
            logic dec;
            // A reservation and a commit on the same register cancel out;
            // a commit on an idle register must not underflow.
            assign inc = sb_set && (sb_set_addr == 5'(gi)) && sb_set_ready && !flush;
            assign dec = rf_wen && (rf_waddr == 5'(gi)) && (cnt_reg[gi] != '0) && !flush;
            assign cnt_next[gi] = flush ? '0
                                        : cnt_reg[gi] + CNT_W'(inc) - CNT_W'(dec);
        end
    endgenerate

    always_comb begin
        busy_cnt_next = '0;
        for (int i = 1; i < 32; i++) begin
            if (cnt_next[i] != '0) begin
                busy_cnt_next = busy_cnt_next + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_reg[i] <= '0;
            end
            busy_cnt_reg <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_reg[i] <= cnt_next[i];
            end
            busy_cnt_reg <= busy_cnt_next;
        end
    end

    assign busy_cnt = busy_cnt_reg;

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic             hit;
            logic [CNT_W-1:0] cnt_cur;
            logic             dec_hit;
            logic             busy_next;
            logic [XLEN-1:0]  data_next;
            logic             valid_reg;
            logic             busy_reg;
            logic [XLEN-1:0]  data_reg;

            assign hit     = rf_wen && (rf_waddr == rd_addr[gi]);
            assign cnt_cur = cnt_reg[rd_addr[gi]];
            // The commit retiring in this same cycle already counts as done;
            // a same-cycle reservation is deliberately not visible, so an
            // instruction reading its own destination is not blocked.
            assign dec_hit   = hit && (cnt_cur != '0) && !flush;
            assign busy_next = (rd_addr[gi] != 5'd0) &&
                               ((cnt_cur - CNT_W'(dec_hit)) != '0);
            assign data_next = (rd_addr[gi] == 5'd0) ? '0 :
                               hit                   ? rf_wdata :
                                                       mem[rd_addr[gi]];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end else begin
                    valid_reg <= rd_en[gi];
                    if (rd_en[gi]) begin
                        busy_reg <= busy_next;
                    end
                end
            end

            // Data has no reset: undefined until the first read.
            always_ff @(posedge clk) begin
                if (rd_en[gi]) begin
                    data_reg <= data_next;
                end
            end
        end
    endgenerate

    assign rd0_valid = g_rd[0].valid_reg;
    assign rd1_valid = g_rd[1].valid_reg;
    assign rd0_busy  = g_rd[0].busy_reg;
    assign rd1_busy  = g_rd[1].busy_reg;
    assign rd0_data  = g_rd[0].data_reg;
    assign rd1_data  = g_rd[1].data_reg;

endmodule

// File: doc/riscv_regfile_sb.md
# riscv_regfile_sb

Architectural integer register file with an in-flight write scoreboard, sitting between decode/dispatch (read and reserve side) and the commit stage (write side). It holds x1–x31 and keeps x0 hardwired to zero. Two registered read ports include same-cycle commit-write bypass. A per-register pending-writer counter reports operand hazards so dispatch can stall until producers commit.

## Interface
Parameters:
- XLEN, 32, data width
- CNT_W, 2, pending-writer counter width per register; max in-flight writers per register = 2^CNT_W-1

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- rf_wen  in  1  commit write enable
- rf_waddr  in  5  commit destination
- rf_wdata  in  XLEN  commit data
- rd0_en  in  1  read port 0 request
- rd0_addr  in  5  read port 0 address
- rd1_en  in  1  read port 1 request
- rd1_addr  in  5  read port 1 address
- rd0_data  out  XLEN  port 0 data, registered
- rd1_data  out  XLEN  port 1 data, registered
- rd0_valid  out  1  registered rd0_en
- rd1_valid  out  1  registered rd1_en
- rd0_busy  out  1  port 0 operand has an uncommitted producer, registered
- rd1_busy  out  1  port 1 operand has an uncommitted producer, registered
- sb_set  in  1  dispatch reserves destination sb_set_addr
- sb_set_addr  in  5  reserved destination
- sb_set_ready  out  1  combinational; 0 when cnt[sb_set_addr] is saturated
- flush  in  1  squash all pending reservations
- busy_cnt  out  6  number of registers with nonzero pending count, registered

## Operation
- Storage: 31×XLEN array with no reset. x0 is not stored and always reads 0.
- Write: when rf_wen=1 and rf_waddr≠0, store rf_wdata at posedge. A write to x0 is ignored.
- Read port N: when rdN_en=1, rdN_data gets the following at posedge:
  - 0 if rdN_addr=0;
  - otherwise rf_wdata if rf_wen=1 and rf_waddr=rdN_addr (write-first bypass);
  - otherwise array[rdN_addr].
- Read port N when rdN_en=0: rdN_data and rdN_busy hold their previous values.
- Scoreboard: cnt[r] has CNT_W bits for r=1..31. Reset value is 0.
  - Increment: sb_set=1, sb_set_addr≠0, sb_set_ready=1, flush=0.
  - Decrement: rf_wen=1, rf_waddr≠0, cnt>0, flush=0.
  - Both on the same register in one cycle: cnt is unchanged.
  - Commit to a register with cnt=0: data is written, cnt stays 0 (no underflow).
  - sb_set while saturated: ignored, no increment. Dispatch must hold on sb_set_ready=0.
  - sb_set_ready is forced to 1 for sb_set_addr=0.
- Busy reported on a read (rdN_busy registered at posedge):
  - rdN_busy = (cnt[rdN_addr] minus this cycle's commit decrement) ≠ 0.
  - A same-cycle sb_set is not visible, so an instruction reading its own destination is not blocked.
  - x0 is never busy.
- flush: all cnt go to 0 at posedge, overriding any same-cycle sb_set. A commit write in the flush cycle still updates the array.
- busy_cnt: population count of nonzero cnt after the update; range 0..31.

## Timing
- Read latency: 1 cycle from rdN_en to rdN_data/rdN_valid/rdN_busy.
- Write visibility:
  - through the bypass, in the same cycle's read;
  - through the array, from the next cycle.
- Reset values:
  - rd0_valid, rd1_valid, rd0_busy, rd1_busy = 0;
  - busy_cnt = 0;
  - all cnt = 0;
  - sb_set_ready = 1.
- rd0_data and rd1_data have no reset and are undefined until the first read.
- Reset asserted mid-operation clears the scoreboard and control outputs immediately. Array contents are retained but not guaranteed.
- Critical path: bypass compare plus 32:1 read mux, under 500 ps.

## Test plan
- Write x5=0xDEADBEEF; next cycle read x5 on port 0 -> rd0_data=0xDEADBEEF, rd0_valid=1, rd0_busy=0.
- Same cycle: rf_wen with x7=0x1234 and rd1_addr=7 -> rd1_data=0x1234 one cycle later (bypass). Write to x0=0xFFFFFFFF, then read x0 -> 0.
- sb_set x3 three times (CNT_W=2) -> sb_set_ready=0, busy_cnt=1. A fourth sb_set is ignored. Three commits to x3: rd0_busy on x3 stays 1 until the read in the same cycle as the third commit, which returns 0.
- Same cycle: sb_set x9 and commit x9 with cnt=1 -> cnt stays 1, rd0_busy=1 next read. Commit x4 with cnt=0 -> data written, busy_cnt unchanged.
- sb_set x1, x2, x10 then flush, with a simultaneous sb_set x11 and commit x2=0x55 -> busy_cnt=0, all busy=0, read x2 returns 0x55.
- Assert rst_n low mid-stream with busy_cnt=4 -> busy_cnt, rd*_valid, rd*_busy go to 0 asynchronously; sb_set_ready=1.
